// File: rtl/mem_width_bridge.sv
// rtl/mem_width_bridge.sv - 32-bit CPU bus to narrow fixed-timing memory port bridge
module mem_width_bridge #(
    parameter int DW          = 16,
    parameter int BEAT_CYCLES = 8,
    parameter int SKIP_EMPTY  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [31:0]     s_addr,
    input  logic [31:0]     s_wdata,
    input  logic [3:0]      s_wstrb,
    output logic [31:0]     s_rdata,
    output logic [31:0]     m_addr,
    output logic            m_we,
    output logic            m_re,
    output logic [DW/8-1:0] m_be,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy
);
    localparam int N  = 32 / DW;
    localparam int BW = DW / 8;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t        state;
    logic [31:0]   base_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [KW-1:0] k;
    logic [CW-1:0] cnt;

    logic [31:0]   src_base;
    logic [31:0]   src_wdata;
    logic [3:0]    src_wstrb;
    logic [N-1:0]  sel;
    logic          found;
    logic [KW-1:0] nk;
    logic [31:0]   nk_addr;
    logic [BW-1:0] nk_be;
    logic [DW-1:0] nk_wdata;
    logic          last;

    // In IDLE the first beat is chosen from the live request; afterwards from the latched copy.
    always_comb begin
        src_base  = (state == IDLE) ? (s_addr & ~32'h3) : base_q;
        src_wdata = (state == IDLE) ? s_wdata : wdata_q;
        src_wstrb = (state == IDLE) ? s_wstrb : wstrb_q;
        for (int i = 0; i < N; i++)
            sel[i] = (src_wstrb == 4'd0) || (SKIP_EMPTY == 0) || (src_wstrb[i*BW +: BW] != '0);
        found = 1'b0;
        nk    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i] && ((state == IDLE) || (i > int'(k)))) begin
                found = 1'b1;
                nk    = KW'(i);
            end
        end
        nk_addr  = src_base + 32'(int'(nk) * BW);
        nk_be    = (src_wstrb == 4'd0) ? '1 : src_wstrb[int'(nk)*BW +: BW];
        nk_wdata = src_wdata[int'(nk)*DW +: DW];
        last     = (cnt == CW'(BEAT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            base_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            k       <= '0;
            cnt     <= '0;
            s_ready <= 1'b0;
            s_rdata <= '0;
            m_addr  <= '0;
            m_we    <= 1'b0;
            m_re    <= 1'b0;
            m_be    <= '0;
            m_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid && !s_ready) begin
                        base_q  <= src_base;
                        wdata_q <= s_wdata;
                        wstrb_q <= s_wstrb;
                        k       <= nk;
                        cnt     <= '0;
                        m_addr  <= nk_addr;
                        m_be    <= nk_be;
                        m_wdata <= nk_wdata;
                        m_we    <= |s_wstrb;
                        m_re    <= ~|s_wstrb;
                        state   <= BEAT;
                    end
                end
                BEAT: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        if (wstrb_q == 4'd0)
                            s_rdata[int'(k)*DW +: DW] <= m_rdata;
                        cnt <= '0;
                        if (found) begin
                            k       <= nk;
                            m_addr  <= nk_addr;
                            m_be    <= nk_be;
                            m_wdata <= nk_wdata;
                        end else begin
                            state   <= DONE;
                            s_ready <= 1'b1;
                            m_addr  <= '0;
                            m_we    <= 1'b0;
                            m_re    <= 1'b0;
                            m_be    <= '0;
                            m_wdata <= '0;
                        end
                    end
                end
                DONE: begin
                    s_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_width_bridge.sv
// tb/tb_mem_width_bridge.sv - self-checking bench for mem_width_bridge in three configurations
module tb_mem_width_bridge;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    logic [31:0] ma0, ma1, ma2, rdat0, rdat1, rdat2;
    logic        we0, we1, we2, re0, re1, re2, rdy0, rdy1, rdy2, bsy0, bsy1, bsy2;
    logic [1:0]  be0, be1;
    logic [0:0]  be2;
    logic [15:0] wd0, wd1, rd0, rd1;
    logic [7:0]  wd2, rd2;

    logic [7:0]  mem [256];
    logic        good [ND];
    logic [31:0] exp_rd [ND];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Memory answers with inverted data except on the cycle the bridge is meant to sample.
    assign rd0 = good[0] ? {mem[ma0[7:0] + 8'd1], mem[ma0[7:0]]} : ~{mem[ma0[7:0] + 8'd1], mem[ma0[7:0]]};
    assign rd1 = good[1] ? {mem[ma1[7:0] + 8'd1], mem[ma1[7:0]]} : ~{mem[ma1[7:0] + 8'd1], mem[ma1[7:0]]};
    assign rd2 = good[2] ? mem[ma2[7:0]] : ~mem[ma2[7:0]];

    mem_width_bridge #(.DW(16), .BEAT_CYCLES(8), .SKIP_EMPTY(1)) u0 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy0), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(rdat0), .m_addr(ma0), .m_we(we0),
        .m_re(re0), .m_be(be0), .m_wdata(wd0), .m_rdata(rd0), .busy(bsy0));
    mem_width_bridge #(.DW(16), .BEAT_CYCLES(3), .SKIP_EMPTY(0)) u1 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy1), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(rdat1), .m_addr(ma1), .m_we(we1),
        .m_re(re1), .m_be(be1), .m_wdata(wd1), .m_rdata(rd1), .busy(bsy1));
    mem_width_bridge #(.DW(8), .BEAT_CYCLES(1), .SKIP_EMPTY(1)) u2 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy2), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(rdat2), .m_addr(ma2), .m_we(we2),
        .m_re(re2), .m_be(be2), .m_wdata(wd2), .m_rdata(rd2), .busy(bsy2));

    function automatic int dw_of(input int d);
        return (d == 2) ? 8 : 16;
    endfunction
    function automatic int bc_of(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 3 : 1);
    endfunction
    function automatic int sk_of(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    task automatic chk(input string tag, input int d, input int t, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, d, t, o, e);
        end
    endtask

    task automatic sample(input int d, output logic [31:0] a, output logic [31:0] b, output logic [31:0] w,
                          output logic [31:0] we_o, output logic [31:0] re_o, output logic [31:0] y,
                          output logic [31:0] bz, output logic [31:0] rd);
        case (d)
            0: begin a = ma0; b = 32'(be0); w = 32'(wd0); we_o = 32'(we0); re_o = 32'(re0);
                     y = 32'(rdy0); bz = 32'(bsy0); rd = rdat0; end
            1: begin a = ma1; b = 32'(be1); w = 32'(wd1); we_o = 32'(we1); re_o = 32'(re1);
                     y = 32'(rdy1); bz = 32'(bsy1); rd = rdat1; end
            default: begin a = ma2; b = 32'(be2); w = 32'(wd2); we_o = 32'(we2); re_o = 32'(re2);
                     y = 32'(rdy2); bz = 32'(bsy2); rd = rdat2; end
        endcase
    endtask

    task automatic check_idle(input string tag, input int t);
        logic [31:0] a, b, w, we_o, re_o, y, bz, rd;
        for (int d = 0; d < ND; d++) begin
            sample(d, a, b, w, we_o, re_o, y, bz, rd);
            chk({tag, "_addr"}, d, t, a, 32'd0);
            chk({tag, "_ctl"}, d, t, {b[3:0], w[15:0], we_o[0], re_o[0], y[0], bz[0]}, 32'd0);
            chk({tag, "_rdata"}, d, t, rd, exp_rd[d]);
        end
    endtask

    // Entered and left at a falling edge with every bridge idle; that cycle is cycle 0.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdat, input logic [3:0] st);
        logic [31:0] base, rdm, a, b, w, we_o, re_o, y, bz, rd, ea, eb, ew, ewe, ere, ey, ebz;
        int nb [ND];
        int beats [ND][4];
        int tmax, dw, bw, bc, k;
        base = addr & ~32'h3;
        rdm  = {mem[base[7:0] + 8'd3], mem[base[7:0] + 8'd2], mem[base[7:0] + 8'd1], mem[base[7:0]]};
        tmax = 0;
        for (int d = 0; d < ND; d++) begin
            dw = dw_of(d);
            bw = dw / 8;
            nb[d] = 0;
            for (int kk = 0; kk < 32 / dw; kk++) begin
                if (st == 4'd0 || sk_of(d) == 0 || ((int'(st) >> (kk * bw)) & ((1 << bw) - 1)) != 0) begin
                    beats[d][nb[d]] = kk;
                    nb[d]++;
                end
            end
            if (nb[d] * bc_of(d) + 1 > tmax) tmax = nb[d] * bc_of(d) + 1;
        end
        s_valid = 1'b1;
        s_addr  = addr;
        s_wdata = wdat;
        s_wstrb = st;
        for (int d = 0; d < ND; d++) good[d] = 1'b0;
        for (int t = 1; t <= tmax + 1; t++) begin
            @(negedge clk);
            if (t == 1) begin
                s_valid = 1'b0;
                s_addr  = $urandom;
                s_wdata = $urandom;
                s_wstrb = 4'($urandom);
            end
            for (int d = 0; d < ND; d++) begin
                dw = dw_of(d);
                bw = dw / 8;
                bc = bc_of(d);
                sample(d, a, b, w, we_o, re_o, y, bz, rd);
                ea = 0; eb = 0; ew = 0; ewe = 0; ere = 0; ey = 0; ebz = 0;
                if (t <= nb[d] * bc) begin
                    k   = beats[d][(t - 1) / bc];
                    ea  = base + 32'(k * bw);
                    eb  = (st == 4'd0) ? 32'((1 << bw) - 1) : 32'((int'(st) >> (k * bw)) & ((1 << bw) - 1));
                    ew  = 32'((64'(wdat) >> (k * dw)) & ((64'd1 << dw) - 1));
                    ewe = 32'(st != 4'd0);
                    ere = 32'(st == 4'd0);
                    ebz = 1;
                end else if (t == nb[d] * bc + 1) begin
                    ey  = 1;
                    ebz = 1;
                    if (st == 4'd0) exp_rd[d] = rdm;
                end
                chk("m_addr", d, t, a, ea);
                chk("m_be", d, t, b, eb);
                chk("m_wdata", d, t, w, ew);
                chk("m_we", d, t, we_o, ewe);
                chk("m_re", d, t, re_o, ere);
                chk("s_ready", d, t, y, ey);
                chk("busy", d, t, bz, ebz);
                if (t > nb[d] * bc) chk("s_rdata", d, t, rd, exp_rd[d]);
                good[d] = (t <= nb[d] * bc) && (t % bc == 0);
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < ND; d++) begin
            exp_rd[d] = 32'd0;
            good[d] = 1'b0;
        end
    endtask

    initial begin
        int pulses;
        logic [31:0] rdm;
        reset = 1'b1;
        s_valid = 1'b0;
        s_addr = '0;
        s_wdata = '0;
        s_wstrb = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int d = 0; d < ND; d++) begin
            good[d] = 1'b0;
            exp_rd[d] = 32'd0;
        end
        repeat (2) @(negedge clk);
        check_idle("reset", 0);
        reset = 1'b0;

        mem[4] = 8'hEF; mem[5] = 8'hBE; mem[6] = 8'hAD; mem[7] = 8'hDE;
        run_txn(32'h2000_0006, 32'h0, 4'b0000);
        chk("dir_read16", 0, 0, rdat0, 32'hDEAD_BEEF);
        run_txn(32'h2000_0008, 32'h1234_5678, 4'b1111);
        run_txn(32'h2000_0040, 32'hCAFE_F00D, 4'b0100);
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
        run_txn(32'h2000_0010, 32'h0, 4'b0000);
        chk("dir_read8", 2, 0, rdat2, 32'h4433_2211);

        s_valid = 1'b1; s_addr = 32'h0000_0020; s_wstrb = 4'b0000;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_re", 0, 3, 32'(re0), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < ND; d++) exp_rd[d] = 32'd0;
        check_idle("midreset", 5);
        pulses = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            pulses += int'(rdy0) + int'(rdy1) + int'(rdy2);
        end
        chk("no_ready_after_reset", 0, 0, 32'(pulses), 32'd0);
        run_txn(32'h2000_0004, 32'h0, 4'b0000);

        for (int i = 0; i < 25; i++)
            run_txn($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom));

        // Back-to-back reads on the 16-bit/8-cycle bridge with s_valid held high.
        rdm = {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]};
        s_valid = 1'b1; s_addr = 32'h1000_0030; s_wdata = 32'h0; s_wstrb = 4'b0000;
        pulses = 0;
        for (int t = 1; t <= 36; t++) begin
            int tt;
            @(negedge clk);
            pulses += int'(rdy0);
            if (t == 17) chk("b2b_ready1", 0, t, 32'(rdy0), 32'd1);
            if (t == 18) chk("b2b_gap", 0, t, {30'd0, bsy0, re0}, 32'd0);
            if (t == 19) chk("b2b_start", 0, t, {ma0[30:0], re0}, {31'h1000_0030, 1'b1});
            if (t == 35) begin
                s_valid = 1'b0;
                chk("b2b_ready2", 0, t, 32'(rdy0), 32'd1);
                chk("b2b_rdata", 0, t, rdat0, rdm);
            end
            tt = (t <= 17) ? t : t - 18;
            good[0] = (tt >= 1) && (tt <= 16) && (tt % 8 == 0);
        end
        chk("b2b_pulses", 0, 36, 32'(pulses), 32'd2);
        pulse_reset();
        check_idle("final", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_width_bridge.md
# mem_width_bridge

Parametrised bridge from the 32-bit CPU native memory bus (valid/ready, byte strobes) to a narrower fixed-timing memory port. It splits each 32-bit access into 32/DW beats, each held for a configurable number of cycles, and assembles read data from the beats. It generalises the two-beat, 8-cycle, 16-bit SDRAM split in the SoC top to 8/16/32-bit memories with any beat length, and adds optional skipping of write beats that have no enabled bytes. It sits between the iomem decode and an SDRAM or SRAM controller.

## Interface
Parameters:
- DW, 16: memory data width; legal values 8, 16, 32. N = 32/DW beats per access.
- BEAT_CYCLES, 8: cycles each beat is held on the memory port; at least 1.
- SKIP_EMPTY, 1: 1 = write beats whose strobe slice is all-zero are not issued.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous reset, active-high.
- s_valid  in  1  CPU request valid.
- s_ready  out  1  one-cycle completion pulse.
- s_addr  in  32  byte address; bits [1:0] are ignored.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte strobes; 0 means read.
- s_rdata  out  32  assembled read data.
- m_addr  out  32  beat byte address.
- m_we  out  1  beat is a write.
- m_re  out  1  beat is a read.
- m_be  out  DW/8  beat byte enables.
- m_wdata  out  DW  beat write data.
- m_rdata  in  DW  memory read data.
- busy  out  1  FSM is not in IDLE.

## Operation
- FSM states: IDLE, BEAT, DONE.
- **IDLE → BEAT** when s_valid is high and s_ready is low:
  - latch {s_addr[31:2],2'b00}, s_wdata and s_wstrb;
  - type = write if s_wstrb != 0, otherwise read;
  - select the first beat k;
  - clear the cycle counter cnt.
- **Write with SKIP_EMPTY=1 and no beat with a non-zero slice:** cannot occur, since a zero strobe means read.
- **Beat k signals:**
  - m_addr = base + k*(DW/8);
  - m_be = latched s_wstrb slice [k*DW/8 +: DW/8] for writes, all ones for reads;
  - m_wdata = latched s_wdata[k*DW +: DW];
  - m_we or m_re is high for the whole beat.
- **Beat selection:**
  - Reads issue all beats 0..N-1.
  - Writes with SKIP_EMPTY=1 issue only the beats whose slice is non-zero, in ascending order.
  - Writes with SKIP_EMPTY=0 issue all beats; an empty slice gives m_we=1 with m_be=0.
- **In BEAT:**
  - cnt increments every cycle.
  - When cnt == BEAT_CYCLES-1, a read stores m_rdata into s_rdata[k*DW +: DW].
  - On that same cycle, go to the next selected beat with cnt=0, or to DONE if none remains.
- **DONE:** s_ready=1 for exactly one cycle, then IDLE. s_rdata holds its value until the next read overwrites it.
- **Unwritten s_rdata lanes:** not reachable, because reads always fill all lanes.
- **s_* changes after acceptance:** ignored. If s_valid drops mid-transaction, the transaction still completes and s_ready still pulses.
- **DW=32:** single beat; a pass-through with BEAT_CYCLES latency.

## Timing
- **Reset values** (reset high at a clock edge):
  - state IDLE, cnt 0;
  - s_ready, m_we, m_re, busy 0;
  - m_addr, m_be, m_wdata, s_rdata 0.
- **Reset mid-beat:** the access is aborted; no s_ready pulse; memory strobes drop on the next edge.
- **Memory outputs** are registered and are 0 in IDLE and DONE.
- **Latency:** with s_valid sampled in IDLE at cycle 0:
  - the first beat is on the port from cycle 1;
  - with B issued beats, s_ready is high at cycle B*BEAT_CYCLES+1;
  - s_rdata is valid in that same cycle.
- **Back-to-back:** the earliest next acceptance is the IDLE cycle after DONE, so there are 2 non-beat cycles between accesses.
- **Read sampling:** m_rdata is sampled only on the last cycle of each read beat.

## Test plan
- **Read, DW=16, BEAT_CYCLES=8:** read at 0x2000_0006. Required:
  - beat 0 m_addr=0x2000_0004, beat 1 m_addr=0x2000_0006, both with m_be=2'b11;
  - memory returns 0xBEEF then 0xDEAD;
  - s_rdata=0xDEAD_BEEF with s_ready at cycle 17.
- **Full write, DW=16:** wdata 0x1234_5678, wstrb 4'b1111. Required:
  - beat 0 m_wdata=0x5678, be=11;
  - beat 1 m_wdata=0x1234, be=11;
  - s_ready at cycle 17.
- **Partial write, DW=16:** wstrb 4'b0100.
  - SKIP_EMPTY=1: one beat, m_addr=base+2, be=2'b01, s_ready at cycle 9.
  - SKIP_EMPTY=0: beat 0 has m_we=1 and be=00, s_ready at cycle 17.
- **Read, DW=8, BEAT_CYCLES=1:** memory returns 0x11, 0x22, 0x33, 0x44. Required: addresses base+0..3, s_rdata=0x4433_2211, s_ready at cycle 5.
- **Reset mid-operation:** assert reset at cnt=3 of beat 0. Required:
  - all outputs 0 on the next cycle;
  - no s_ready pulse;
  - a following read completes normally.
- **Back-to-back:** s_valid held high across two reads. Required: the second beat train starts the cycle after the DONE→IDLE cycle, and exactly one s_ready pulse per access.
